femtorv_mem_arbiter: RTL and testbench
======================================

# femtorv_mem_arbiter

Two-requester memory arbiter that shares one memory port between the FemtoRV32 core and an auxiliary master, such as a boot loader, DMA engine or video fetcher. It sits between the core's `mem_*` bus and the RAM/peripheral bus. Requesters and the memory port all use the same protocol:
- a one-cycle `rstrb` pulse starts a read; a one-cycle non-zero `wmask` starts a write;
- `rbusy`/`wbusy` high means the transfer has not completed;
- read data is valid once `rbusy` is low.

The block latches each request, grants the memory port to one requester at a time, and returns read data in per-requester holding registers.

## Interface
Parameters:
- `ADDR_WIDTH`, 24, number of address bits stored and forwarded; `mem_addr[31:ADDR_WIDTH]` is driven 0.

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_addr`  in  32  CPU address
- `cpu_wdata`  in  32  CPU write data
- `cpu_wmask`  in  4  CPU byte write mask; non-zero for one cycle = write request
- `cpu_rstrb`  in  1  CPU read strobe, one cycle
- `cpu_rdata`  out  32  CPU read data holding register
- `cpu_rbusy`  out  1  CPU read pending
- `cpu_wbusy`  out  1  CPU write pending
- `aux_addr`, `aux_wdata`, `aux_wmask`, `aux_rstrb`, `aux_rdata`, `aux_rbusy`, `aux_wbusy`: same as `cpu_*`, auxiliary master
- `mem_addr`  out  32  memory address
- `mem_wdata`  out  32  memory write data
- `mem_wmask`  out  4  memory byte mask, one-cycle pulse
- `mem_rstrb`  out  1  memory read strobe, one-cycle pulse
- `mem_rdata`  in  32  memory read data
- `mem_rbusy`  in  1  memory read in progress
- `mem_wbusy`  in  1  memory write in progress

## Operation
- **Capture, per requester:** on a strobe (`rstrb` or `|wmask`) with nothing pending, the block registers `addr[ADDR_WIDTH-1:0]`, `wdata` and `wmask`, and sets `pend_rd` or `pend_wr`.
  - If `wmask != 0`, the request is a write and `rstrb` is ignored.
- **Busy outputs:** `x_rbusy = pend_rd`, `x_wbusy = pend_wr`, both registered. Busy is therefore high in the cycle after the strobe, which is what FemtoRV32's WAIT_INSTR and WAIT_ALU_OR_MEM states sample.
- **Strobe while pending:** a strobe from a requester that already has a pending request is dropped. It has no effect on state; this is a protocol violation for the bench to assert against.
- **FSM, two states:**
  - IDLE: if any pend flag is set, select a winner by the arbitration rule and drive `mem_addr`/`mem_wdata` from the winner's registers. Pulse `mem_rstrb` (read) or `mem_wmask` (write) for exactly this cycle, latch `grant`, and go to WAIT.
  - WAIT: `mem_addr`/`mem_wdata` are held from the granted registers and strobes are 0. When `!mem_rbusy & !mem_wbusy`:
    - for a read, load `x_rdata <= mem_rdata`;
    - clear the granted pend flag and go to IDLE.
- **Holding registers:** `x_rdata` holds its value until the next completed read for that requester, and is not modified by writes or by the other requester's traffic.
- **Arbitration (default):** fixed priority, CPU over aux. Aux can starve while the CPU issues back-to-back requests.
- **Capture during WAIT:** a strobe arriving while the FSM is in WAIT is captured normally and served after the current transfer.
- **Simultaneous requests:** CPU and aux strobes in the same cycle are both captured; the winner is served first and the loser stays pending.
- **Outputs in IDLE with nothing pending:** `mem_rstrb = 0`, `mem_wmask = 0`, and `mem_addr`/`mem_wdata` hold their last value.
- **Reset values:**
  - state IDLE, all pend flags 0, `grant` = CPU;
  - `cpu_rdata = aux_rdata = 0`, all busy outputs 0;
  - `mem_rstrb = 0`, `mem_wmask = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- **Reset mid-transfer:** the in-flight transfer is abandoned with no completion and no data capture. Memory is reset with the same `reset`.

## Timing
- Zero-wait memory, uncontended read:
  - cycle 0: requester strobes;
  - cycle 1: busy=1 and `mem_rstrb`=1;
  - cycle 2: WAIT sees `mem_rbusy`=0 and captures;
  - cycle 3: busy=0 and `rdata` valid.
- Requester latency is 3 cycles plus the number of memory wait cycles.
- Back-to-back transfers: memory-port throughput is one transfer per 2 cycles (IDLE + WAIT) at zero wait.
- The memory must assert `mem_rbusy`/`mem_wbusy` in the cycle after the strobe if it is not ready. The block samples them only in WAIT.
- There is no combinational path from any requester input to any requester output.

## Configuration
- `FEMTO_ARB_ROUND_ROBIN_EN` defined: the arbiter uses a 1-bit `last` register, set to the winner on each grant, reset to aux.
  - On contention, the requester that is not `last` wins, so the CPU wins the first contention after reset.
  - Requests are served alternately under saturation; neither requester waits more than one transfer.
- Macro undefined: fixed CPU priority and no `last` register.

## Test plan
- **Zero-wait CPU read:** `cpu_rstrb` at cycle 0, `cpu_addr=0x000104`, memory returns `0xDEADBEEF` with busy low.
  - Required: `mem_rstrb` at cycle 1 with `mem_addr=0x000104`, `cpu_rbusy=1` in cycles 1–2, `cpu_rdata=0xDEADBEEF` and `cpu_rbusy=0` at cycle 3.
- **Wait states:** aux write, `aux_wmask=4'b0100`, `aux_wdata=0x00AB0000`; memory holds `mem_wbusy` for 4 cycles.
  - Required: `mem_wmask=4'b0100` for exactly one cycle, `aux_wbusy` high for 6 cycles, `aux_rdata` unchanged.
- **Contention, default build:** CPU and aux both strobe in cycle 0.
  - Required: CPU is granted first, aux `mem_rstrb` at cycle 3, `aux_rbusy` falls at cycle 5.
  - Required: `cpu_rdata` and `aux_rdata` each hold their own memory word.
- **Round robin, `FEMTO_ARB_ROUND_ROBIN_EN`:** both requesters re-strobe immediately on busy falling, for 8 transfers.
  - Required: grants alternate C,A,C,A…
- **Reset mid-WAIT:** `reset=1` while `mem_rbusy=1`.
  - Required: next cycle all busy outputs are 0, the FSM is IDLE, both `rdata` registers are 0, and there are no strobes.
  - Required: a subsequent CPU read completes normally.
- **Strobe while pending:** a second `cpu_rstrb` during `cpu_rbusy=1`.
  - Required: only one `mem_rstrb` is issued, and `mem_addr` matches the first address.

Source files
------------

// File: rtl/femtorv_mem_arbiter.sv
// femtorv_mem_arbiter
//
// Shares one memory port between the FemtoRV32 core (cpu_*) and an
// auxiliary master (aux_*). Each requester's strobe is latched into a
// per-requester request register. A two-state FSM (IDLE/WAIT) grants the
// memory port to one request at a time. Read data returns through
// per-requester holding registers.
//
// Ports
//   clk, reset        : single clock; synchronous active-high reset
//   cpu_addr/wdata    : CPU request address and write data
//   cpu_wmask         : CPU byte mask; non-zero for one cycle = write
//   cpu_rstrb         : CPU one-cycle read strobe
//   cpu_rdata         : CPU read-data holding register
//   cpu_rbusy/wbusy   : CPU read / write pending (registered)
//   aux_*             : same set for the auxiliary master
//   mem_addr/wdata    : memory address / write data
//                       (mem_addr[31:ADDR_WIDTH] is always 0)
//   mem_wmask         : memory byte mask, one-cycle pulse
//   mem_rstrb         : memory read strobe, one-cycle pulse
//   mem_rdata         : memory read data
//   mem_rbusy/wbusy   : memory transfer still in progress
//
// Build option
//   FEMTO_ARB_ROUND_ROBIN_EN : when defined, contention is resolved
//   round-robin using a 1-bit 'last' register. When undefined, the CPU
//   has fixed priority over aux.
//
// Memory-port strobes and the address/data mux are decoded from
// registered state only. No requester input reaches any requester
// output combinationally.

module femtorv_mem_arbiter #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  input  logic        cpu_rstrb,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rbusy,
  output logic        cpu_wbusy,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  input  logic [3:0]  aux_wmask,
  input  logic        aux_rstrb,
  output logic [31:0] aux_rdata,
  output logic        aux_rbusy,
  output logic        aux_wbusy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy
);

  typedef enum logic { S_IDLE = 1'b0, S_WAIT = 1'b1 } state_t;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_AUX = 1'b1;

  state_t                state;
  logic                  grant;

  logic                  cpu_pend_rd, cpu_pend_wr;
  logic                  aux_pend_rd, aux_pend_wr;
  logic [ADDR_WIDTH-1:0] cpu_addr_q, aux_addr_q;
  logic [31:0]           cpu_wdata_q, aux_wdata_q;
  logic [3:0]            cpu_wmask_q, aux_wmask_q;

  // Last value presented on the memory port, kept while IDLE with nothing to do.
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [31:0]           wdata_hold;

  logic                  cpu_pend, aux_pend, any_pend;
  logic                  cpu_cap, aux_cap;
  logic                  issue, done, winner;
  logic [ADDR_WIDTH-1:0] addr_sel, addr_out;
  logic [31:0]           wdata_sel;
  logic [3:0]            wmask_sel;
  logic                  sel_wr;

  // Upper requester address bits are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_WIDTH], aux_addr[31:ADDR_WIDTH]};

  assign cpu_pend = cpu_pend_rd | cpu_pend_wr;
  assign aux_pend = aux_pend_rd | aux_pend_wr;
  assign any_pend = cpu_pend | aux_pend;

  // A strobe is only accepted when that requester has nothing outstanding.
  assign cpu_cap = !cpu_pend && (cpu_rstrb || (cpu_wmask != 4'd0));
  assign aux_cap = !aux_pend && (aux_rstrb || (aux_wmask != 4'd0));

  assign issue = (state == S_IDLE) && any_pend;
  assign done  = (state == S_WAIT) && !mem_rbusy && !mem_wbusy;

`ifdef FEMTO_ARB_ROUND_ROBIN_EN
  logic last;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    if (cpu_pend && aux_pend) winner = ~last;
    else                      winner = cpu_pend ? SEL_CPU : SEL_AUX;
  end
`else
  always_comb winner = cpu_pend ? SEL_CPU : SEL_AUX;
`endif

  always_comb begin
    addr_sel  = (winner == SEL_AUX) ? aux_addr_q  : cpu_addr_q;
    wdata_sel = (winner == SEL_AUX) ? aux_wdata_q : cpu_wdata_q;
    wmask_sel = (winner == SEL_AUX) ? aux_wmask_q : cpu_wmask_q;
    sel_wr    = (winner == SEL_AUX) ? aux_pend_wr : cpu_pend_wr;
    addr_out  = issue ? addr_sel  : addr_hold;
    mem_wdata = issue ? wdata_sel : wdata_hold;
    mem_rstrb = issue && !sel_wr;
    mem_wmask = (issue && sel_wr) ? wmask_sel : 4'd0;
  end

  assign mem_addr  = 32'(addr_out);

  assign cpu_rbusy = cpu_pend_rd;
  assign cpu_wbusy = cpu_pend_wr;
  assign aux_rbusy = aux_pend_rd;
  assign aux_wbusy = aux_pend_wr;

  // Request payload registers: only meaningful while the matching pend flag is set.
  always_ff @(posedge clk) begin
    if (cpu_cap) begin
      cpu_addr_q  <= cpu_addr[ADDR_WIDTH-1:0];
      cpu_wdata_q <= cpu_wdata;
      cpu_wmask_q <= cpu_wmask;
    end
    if (aux_cap) begin
      aux_addr_q  <= aux_addr[ADDR_WIDTH-1:0];
      aux_wdata_q <= aux_wdata;
      aux_wmask_q <= aux_wmask;
    end
  end

  // Pend flags, FSM and holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= SEL_CPU;
      cpu_pend_rd <= 1'b0;
      cpu_pend_wr <= 1'b0;
      aux_pend_rd <= 1'b0;
      aux_pend_wr <= 1'b0;
      cpu_rdata   <= 32'd0;
      aux_rdata   <= 32'd0;
      addr_hold   <= '0;
      wdata_hold  <= 32'd0;
`ifdef FEMTO_ARB_ROUND_ROBIN_EN
      last        <= SEL_AUX;
`endif
    end else begin
      // A non-zero mask makes it a write regardless of rstrb.
      if (cpu_cap) begin
        cpu_pend_wr <= (cpu_wmask != 4'd0);
        cpu_pend_rd <= (cpu_wmask == 4'd0);
      end
      if (aux_cap) begin
        aux_pend_wr <= (aux_wmask != 4'd0);
        aux_pend_rd <= (aux_wmask == 4'd0);
      end

      // Capture and completion never touch the same requester in one cycle:
      // capture needs that requester idle, completion needs it pending.
      case (state)
        S_IDLE: begin
          if (issue) begin
            grant      <= winner;
            addr_hold  <= addr_sel;
            wdata_hold <= wdata_sel;
            state      <= S_WAIT;
`ifdef FEMTO_ARB_ROUND_ROBIN_EN
            last       <= winner;
`endif
          end
        end
        S_WAIT: begin
          if (done) begin
            if (grant == SEL_CPU) begin
              if (cpu_pend_rd) cpu_rdata <= mem_rdata;
              cpu_pend_rd <= 1'b0;
              cpu_pend_wr <= 1'b0;
            end else begin
              if (aux_pend_rd) aux_rdata <= mem_rdata;
              aux_pend_rd <= 1'b0;
              aux_pend_wr <= 1'b0;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_femtorv_mem_arbiter.sv
// Randomized bench for femtorv_mem_arbiter.
// Two requesters issue random reads/writes, occasionally re-strobing while busy.
// A memory model with random wait states sits on the memory port.
// A transaction-level reference (per-requester outstanding request, arbitration
// rule, reference memory contents) predicts busy flags, memory-port strobes,
// addresses and returned read data every cycle.
// Occasional resets are applied while a memory transfer is stalled.
module tb_femtorv_mem_arbiter;

  localparam int          AW    = 24;
  localparam logic [31:0] AMASK = 32'h00FF_FFFF;
  localparam int          NCYC  = 2400;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wmask;
  logic        cpu_rstrb, cpu_rbusy, cpu_wbusy;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic [3:0]  aux_wmask;
  logic        aux_rstrb, aux_rbusy, aux_wbusy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, mem_rbusy, mem_wbusy;

  femtorv_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_rstrb(cpu_rstrb), .cpu_rdata(cpu_rdata), .cpu_rbusy(cpu_rbusy),
    .cpu_wbusy(cpu_wbusy),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_wmask(aux_wmask),
    .aux_rstrb(aux_rstrb), .aux_rdata(aux_rdata), .aux_rbusy(aux_rbusy),
    .aux_wbusy(aux_wbusy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference state: one outstanding request per requester (0 = cpu, 1 = aux).
  logic        m_pend   [2];
  logic        m_wr     [2];
  logic        m_issued [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_mask   [2];
  logic [31:0] m_rdata  [2];
  int          m_done   [2];

  // Transfer currently on the memory port.
  logic        fl_valid;
  logic        fl_wr;
  int          fl_start, fl_busy_end;
  logic [31:0] fl_word;

  logic [31:0] hold_addr, hold_wdata;
  logic        rr_last;
  logic [31:0] mem_arr [8];
  int          served;

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_pend[r] = 1'b0; m_wr[r] = 1'b0; m_issued[r] = 1'b0;
      m_addr[r] = 32'd0; m_wdata[r] = 32'd0; m_mask[r] = 4'd0;
      m_rdata[r] = 32'd0; m_done[r] = 0;
    end
    fl_valid = 1'b0; fl_wr = 1'b0; fl_start = 0; fl_busy_end = 0; fl_word = 32'd0;
    hold_addr = 32'd0; hold_wdata = 32'd0;
    rr_last = 1'b1;
  endtask

  task automatic drive_req(input int r, input logic rs, input logic [3:0] wm,
                           input logic [31:0] a, input logic [31:0] d);
    if (r == 0) begin
      cpu_rstrb = rs; cpu_wmask = wm; cpu_addr = a; cpu_wdata = d;
    end else begin
      aux_rstrb = rs; aux_wmask = wm; aux_addr = a; aux_wdata = d;
    end
  endtask

  function automatic int pick_winner();
`ifdef FEMTO_ARB_ROUND_ROBIN_EN
    if (m_pend[0] && m_pend[1]) return rr_last ? 0 : 1;
`else
    if (m_pend[0] && m_pend[1]) return 0;
`endif
    return m_pend[0] ? 0 : 1;
  endfunction

  initial begin
    int          win, w, rate, next_reset;
    logic        do_reset;
    logic [2:0]  idx;
    logic [31:0] a, d;
    logic [3:0]  wm;

    reset = 1'b1;
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    mem_rbusy = 1'b0; mem_wbusy = 1'b0; mem_rdata = 32'd0;
    for (int i = 0; i < 8; i++) mem_arr[i] = $urandom;
    model_reset();
    served = 0;
    next_reset = 500;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      reset = 1'b0;

      // Completion: busy falls and rdata updates the cycle after the memory is seen ready.
      for (int r = 0; r < 2; r++) begin
        if (m_pend[r] && m_issued[r] && cyc == m_done[r]) begin
          if (!m_wr[r]) m_rdata[r] = fl_word;
          m_pend[r] = 1'b0;
          m_issued[r] = 1'b0;
          fl_valid = 1'b0;
          served++;
        end
      end

      chk("cpu_rbusy", 32'(cpu_rbusy), 32'(m_pend[0] && !m_wr[0]));
      chk("cpu_wbusy", 32'(cpu_wbusy), 32'(m_pend[0] &&  m_wr[0]));
      chk("aux_rbusy", 32'(aux_rbusy), 32'(m_pend[1] && !m_wr[1]));
      chk("aux_wbusy", 32'(aux_wbusy), 32'(m_pend[1] &&  m_wr[1]));
      chk("cpu_rdata", cpu_rdata, m_rdata[0]);
      chk("aux_rdata", aux_rdata, m_rdata[1]);

      // The port is granted in the first cycle it is free and something is pending.
      if (!fl_valid && (m_pend[0] || m_pend[1])) begin
        win = pick_winner();
        chk(win == 0 ? "grant_cpu_rstrb" : "grant_aux_rstrb", 32'(mem_rstrb), 32'(!m_wr[win]));
        chk(win == 0 ? "grant_cpu_wmask" : "grant_aux_wmask", 32'(mem_wmask),
            m_wr[win] ? 32'(m_mask[win]) : 32'd0);
        chk("grant_mem_addr", mem_addr, m_addr[win] & AMASK);
        chk("grant_mem_wdata", mem_wdata, m_wdata[win]);
        hold_addr  = m_addr[win] & AMASK;
        hold_wdata = m_wdata[win];
        rr_last    = win[0];
        w          = $urandom_range(0, 3);
        fl_valid   = 1'b1;
        fl_wr      = m_wr[win];
        fl_start   = cyc;
        fl_busy_end = cyc + w;
        m_done[win] = cyc + w + 2;
        m_issued[win] = 1'b1;
        idx = m_addr[win][4:2];
        if (m_wr[win]) begin
          for (int b = 0; b < 4; b++)
            if (m_mask[win][b]) mem_arr[idx][8*b +: 8] = m_wdata[win][8*b +: 8];
        end else begin
          fl_word = mem_arr[idx];
        end
      end else begin
        chk("idle_mem_rstrb", 32'(mem_rstrb), 32'd0);
        chk("idle_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("hold_mem_addr", mem_addr, hold_addr);
        chk("hold_mem_wdata", mem_wdata, hold_wdata);
      end

      // Memory response for this cycle: busy for w cycles after the strobe.
      mem_rbusy = fl_valid && !fl_wr && cyc > fl_start && cyc <= fl_busy_end;
      mem_wbusy = fl_valid &&  fl_wr && cyc > fl_start && cyc <= fl_busy_end;
      mem_rdata = (fl_valid && !fl_wr && !mem_rbusy) ? fl_word : $urandom;

      do_reset = (cyc >= next_reset) && (mem_rbusy || mem_wbusy);
      if (do_reset) begin
        reset = 1'b1;
        next_reset = cyc + 600;
      end

      // Requester stimulus. The first half is sparse; the second half saturates.
      rate = (cyc < NCYC / 2) ? 30 : 100;
      for (int r = 0; r < 2; r++) begin
        a = $urandom;
        d = $urandom;
        if (!do_reset && !m_pend[r] && $urandom_range(0, 99) < rate) begin
          if ($urandom_range(0, 1) == 1) begin
            wm = 4'($urandom_range(1, 15));
            drive_req(r, 1'($urandom_range(0, 1)), wm, a, d);
            m_wr[r] = 1'b1; m_mask[r] = wm;
          end else begin
            drive_req(r, 1'b1, 4'd0, a, d);
            m_wr[r] = 1'b0; m_mask[r] = 4'd0;
          end
          m_addr[r] = a; m_wdata[r] = d;
          m_pend[r] = 1'b1; m_issued[r] = 1'b0;
        end else if (!do_reset && m_pend[r] && $urandom_range(0, 99) < 15) begin
          // Strobe while pending: must be dropped.
          drive_req(r, 1'b1, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0, a, d);
        end else begin
          drive_req(r, 1'b0, 4'd0, a, d);
        end
      end

      if (do_reset) model_reset();

      @(posedge clk);
      #1;
    end

    chk("transfers_served", 32'(served > 100), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
